ucr_hash_engine: RTL
====================

UCR_HASH_ENGINE -- requirements
Module: ucr_hash_engine

Interface
REQ-001 Parameter K_LO, default 8'h99: round constant for rounds 0..16.
REQ-002 Parameter K_HI, default 8'hA1: round constant for rounds 17..31.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_L  input  1  asynchronous, active-low reset.
REQ-005 fill  input  1  start request; samples bloque_in on the same edge it is accepted.
REQ-006 bloque_in  input  128  message block; byte W[0] = bloque_in[127:120], W[15] = bloque_in[7:0].
REQ-007 H  output  24  hash result {H0,H1,H2}; valid when done=1, then held.
REQ-008 done  output  1  one-cycle pulse marking H valid.
REQ-009 busy  output  1  high while rounds execute; fill ignored.

Function
REQ-010 The FSM SHALL have the states IDLE, ROUND and DONE.
- IDLE: fill=1 -> ROUND.
- ROUND: 32 cycles, round counter i = 0..31; exits to DONE after i=31.
- DONE: exactly one cycle, then IDLE.
REQ-011 Accepting fill SHALL load W[0..15] from bloque_in, set H0=8'h01, H1=8'h89, H2=8'hFE, and clear i.
REQ-012 The schedule for i>=16 SHALL be W[i] = W[i-3] | (W[i-9] ^ W[i-14]), 8-bit.
- Held as a 16-byte shift window computed on the fly; no 32-byte array.
REQ-013 Each ROUND cycle SHALL perform the following update.
- i<=16: k=K_LO, x=H1^H2.
- else: k=K_HI, x=H0^H2.
- H0'=H1; H1'={H2[6:0],H2[7]}; H2'=(H0+x+k+W[i]) mod 256.
- All additions 8-bit, carries discarded.
REQ-014 Latency: a fill accepted at edge N SHALL give done=1 and valid H in the cycle after edge N+32 (33 edges from acceptance to DONE entry).
REQ-015 busy SHALL be 1 exactly in ROUND and 0 in IDLE and DONE.
REQ-016 A fill asserted during ROUND SHALL be ignored, with no queuing and no effect on the result.
REQ-017 A fill asserted while in DONE SHALL be accepted and go directly to ROUND, with REQ-011 applied on that edge.
- done still pulses for the finished block.
REQ-018 The H output SHALL change only on the DONE-entry edge and hold until the next DONE.
- Internal round registers are separate from the H output.
REQ-019 A fill held high continuously SHALL start a new block every 34 cycles (IDLE path) or every 33 cycles (DONE path).

Reset
REQ-020 reset_L=0 SHALL asynchronously force the following values.
- State IDLE; H=24'h0; done=0; busy=0; i=0; W window cleared.
REQ-021 A reset mid-ROUND SHALL abort the block, with no done pulse after release.
REQ-022 fill SHALL be ignored while reset_L=0 and accepted on the first edge after release.

Structure
REQ-023 A shared package SHALL hold the following definitions.
- Initial H constants 8'h01, 8'h89, 8'hFE.
- ROUNDS=32 and the round boundary 16.
- The FSM state encoding.
REQ-024 One sub-module, ucr_hash_sched, SHALL hold the 16-byte W window and emit W[i] each round.
- The round datapath and FSM stay in ucr_hash_engine.

Verification
REQ-025 The bench SHALL cover the following directed scenarios.
- Reset: reset_L=0 for 3 cycles -> H=0, done=0, busy=0; release, fill=1 for 1 cycle -> busy=1 next cycle; done exactly 33 edges after the fill edge.
- Known blocks: bloque_in=128'h0 and bloque_in=128'h000102030405060708090A0B0C0D0E0F -> H matches the bench's bit-exact model of REQ-012/013; the golden value is stored in the bench.
- Fill ignored: fill pulsed at round 5 with a different bloque_in -> H equals the first block's golden value; exactly one done pulse.
- Back-to-back: fill held high for 100 cycles with a constant block -> done pulses at 33-cycle spacing after the first, identical H each time.
- Reset mid-block: reset_L=0 at round 20 -> no done for 40 cycles after release; H=0; next fill gives a correct result.
- Constant override: K_LO=8'h00, K_HI=8'h00 instance -> H matches the model run with zero constants.

Source files
------------

// File: rtl/ucr_hash_pkg.sv
// Shared constants, FSM encoding and small helpers for the UCR hash engine.
// Imported by the engine top and its message-schedule sub-module.
package ucr_hash_pkg;

    localparam int ROUNDS      = 32;
    localparam int ROUND_SPLIT = 16;
    localparam int IDX_W       = 5;
    localparam int WIN_BYTES   = 16;

    localparam logic [7:0] H0_INIT = 8'h01;
    localparam logic [7:0] H1_INIT = 8'h89;
    localparam logic [7:0] H2_INIT = 8'hFE;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } hash_state_e;

    function automatic logic [7:0] rotl1(input logic [7:0] v);
        return {v[6:0], v[7]};
    endfunction

    // Next schedule byte from the taps W[i-3], W[i-9], W[i-14].
    function automatic logic [7:0] sched_next(input logic [7:0] w_m3,
                                              input logic [7:0] w_m9,
                                              input logic [7:0] w_m14);
        return w_m3 | (w_m9 ^ w_m14);
    endfunction

endpackage

// File: rtl/ucr_hash_sched.sv
// Message schedule: a 16-byte sliding window whose head is W[i] for the
// current round; each advance shifts in the next derived byte.
module ucr_hash_sched
    import ucr_hash_pkg::*;
(
    input  logic         clk,
    input  logic         reset_L,
    input  logic         load,
    input  logic         advance,
    input  logic [127:0] bloque_in,
    output logic [7:0]   w_cur
);

    logic [7:0] win [WIN_BYTES];
    logic [7:0] w_new;

    // Window holds W[i..i+15], so W[i+16] taps sit at offsets 13, 7 and 2.
    assign w_new = sched_next(win[13], win[7], win[2]);
    assign w_cur = win[0];

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int j = 0; j < WIN_BYTES; j++) begin
                win[j] <= '0;
            end
        end else if (load) begin
            for (int j = 0; j < WIN_BYTES; j++) begin
                win[j] <= bloque_in[127 - 8*j -: 8];
            end
        end else if (advance) begin
            for (int j = 0; j < WIN_BYTES - 1; j++) begin
                win[j] <= win[j + 1];
            end
            win[WIN_BYTES - 1] <= w_new;
        end
    end

endmodule

// File: rtl/ucr_hash_engine.sv
// UCR hash engine: 32-round compression of one 128-bit block into a 24-bit
// digest {H0,H1,H2}; FSM and round datapath live here, schedule in a sub-module.
module ucr_hash_engine
    import ucr_hash_pkg::*;
#(
    parameter logic [7:0] K_LO = 8'h99,
    parameter logic [7:0] K_HI = 8'hA1
) (
    input  logic         clk,
    input  logic         reset_L,
    input  logic         fill,
    input  logic [127:0] bloque_in,
    output logic [23:0]  H,
    output logic         done,
    output logic         busy,
    output logic [1:0]   dbg_state
);

    // Handshake: fill is a start request taken on any edge where busy=0
    // (IDLE or DONE) and samples bloque_in on that same edge; while busy=1
    // fill is dropped, and done pulses for one cycle with H valid and held.

    hash_state_e      state;
    hash_state_e      state_next;
    logic [IDX_W-1:0] rnd;
    logic [7:0]       h0;
    logic [7:0]       h1;
    logic [7:0]       h2;
    logic [7:0]       w_i;
    logic [7:0]       k_sel;
    logic [7:0]       x_sel;
    logic [7:0]       h2_next;
    logic             load;
    logic             advance;
    logic             last_round;
    logic             hi_phase;

    ucr_hash_sched u_sched (
        .clk       (clk),
        .reset_L   (reset_L),
        .load      (load),
        .advance   (advance),
        .bloque_in (bloque_in),
        .w_cur     (w_i)
    );

    assign last_round = (rnd == IDX_W'(ROUNDS - 1));
    assign hi_phase   = (rnd > IDX_W'(ROUND_SPLIT));
    assign dbg_state  = state;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (fill) state_next = ST_ROUND;
            ST_ROUND: if (last_round) state_next = ST_DONE;
            ST_DONE:  state_next = fill ? ST_ROUND : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        load    = 1'b0;
        advance = 1'b0;
        case (state)
            ST_IDLE: begin
                load = fill;
            end
            ST_ROUND: begin
                busy    = 1'b1;
                advance = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
                load = fill;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Round 16 still belongs to the low-constant phase.
    always_comb begin
        if (hi_phase) begin
            k_sel = K_HI;
            x_sel = h0 ^ h2;
        end else begin
            k_sel = K_LO;
            x_sel = h1 ^ h2;
        end
        h2_next = h0 + x_sel + k_sel + w_i;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            rnd <= '0;
            h0  <= '0;
            h1  <= '0;
            h2  <= '0;
        end else if (load) begin
            rnd <= '0;
            h0  <= H0_INIT;
            h1  <= H1_INIT;
            h2  <= H2_INIT;
        end else if (advance) begin
            rnd <= rnd + 1'b1;
            h0  <= h1;
            h1  <= rotl1(h2);
            h2  <= h2_next;
        end
    end

    // Published digest only moves on the edge that enters DONE.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            H <= '0;
        end else if (advance && last_round) begin
            H <= {h1, rotl1(h2), h2_next};
        end
    end

endmodule
